uart_alu_sequencer: RTL and testbench

- Controller between the UART receiver, the ALU and the UART transmitter.
- Collects three received bytes in order: operand A, operand B, opcode. It then drives the ALU and hands the result to the transmitter with a one-cycle start strobe.
- Frames with bad parity, inter-byte timeouts and bytes arriving while busy are flagged and the sequence resynchronises to operand A.

---
 rtl/uart_alu_sequencer.sv | 79 +++++++
 tb/tb_uart_alu_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: gathers A, B and opcode bytes from the UART receiver, runs the ALU and starts the transmitter
module uart_alu_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int NB_TIMEOUT     = 20
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_rx_frame_valid,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy,
    output logic               o_error,
    output logic               o_overrun
);
    typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX} state_t;
    state_t state, state_next;
    logic [NB_TIMEOUT-1:0] timer;
    logic accepted, bad, receiving, busy_state, timeout;
    logic busy_next, start_next, error_next, overrun_next;
    assign accepted   = i_rx_done & i_rx_frame_valid;
    assign bad        = i_rx_done & ~i_rx_frame_valid;
    assign receiving  = state inside {WAIT_A, WAIT_B, WAIT_OP};
    assign busy_state = ~receiving;
    assign timeout    = (state inside {WAIT_B, WAIT_OP}) && timer == NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state      <= WAIT_A;
            timer      <= '0;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_error    <= 1'b0;
            o_overrun  <= 1'b0;
        end else begin
            state      <= state_next;
            timer      <= (state_next != state) ? '0 :
                          ((state inside {WAIT_B, WAIT_OP}) && timer != '1) ? timer + 1'b1 : timer;
            if (state == WAIT_A && accepted) o_alu_a <= i_rx_data;
            if (state == WAIT_B && accepted) o_alu_b <= i_rx_data;
            if (state == WAIT_OP && accepted) o_alu_op <= i_rx_data[NB_OP-1:0];
            if (state == EXEC) o_tx_data <= i_alu_result;
            o_tx_start <= start_next;
            o_busy     <= busy_next;
            o_error    <= error_next;
            o_overrun  <= overrun_next;
        end
    end
    always_comb begin
        state_next = state;
        case (state)
            WAIT_A:  state_next = accepted ? WAIT_B : WAIT_A;
            WAIT_B:  state_next = accepted ? WAIT_OP : (bad || timeout) ? WAIT_A : WAIT_B;
            WAIT_OP: state_next = accepted ? EXEC : (bad || timeout) ? WAIT_A : WAIT_OP;
            EXEC:    state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: state_next = i_tx_done ? WAIT_A : WAIT_TX;
            default: state_next = WAIT_A;
        endcase
    end
    // an accepted byte beats a timeout landing on the same edge
    always_comb begin
        busy_next    = state_next inside {EXEC, SEND, WAIT_TX};
        start_next   = state_next == SEND;
        error_next   = receiving && (bad || (timeout && !accepted));
        overrun_next = busy_state && i_rx_done;
    end
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb_uart_alu_sequencer: randomized command traffic against a byte-level reference model
module tb_uart_alu_sequencer;
    localparam int TMO = 50;
    logic       clock_tb_i = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_done, rx_frame_valid, tx_done;
    logic [7:0] alu_a, alu_b, alu_result, tx_data;
    logic [5:0] alu_op;
    logic       tx_start, busy, error, overrun;
    int total = 0, bad = 0, err_cnt = 0, ovr_cnt = 0, start_cnt = 0;

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        return op == 6'h20 ? a + b : op == 6'h22 ? a - b : op == 6'h24 ? (a & b) : op == 6'h25 ? (a | b) : (a ^ b);
    endfunction

    assign alu_result = ref_alu(alu_a, alu_b, alu_op);

    uart_alu_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clock(clock_tb_i), .i_reset(reset_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_rx_frame_valid(rx_frame_valid), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .i_alu_result(alu_result), .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
        .o_busy(busy), .o_error(error), .o_overrun(overrun)
    );

    always #5 clock_tb_i = ~clock_tb_i;

    always @(negedge clock_tb_i) begin
        if (error) err_cnt++;
        if (overrun) ovr_cnt++;
        if (tx_start) start_cnt++;
    end

    task automatic tick();
        @(posedge clock_tb_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic v);
        rx_data = d;
        rx_frame_valid = v;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_frame_valid = 1'b1;
        rx_data = 8'($urandom);
    endtask

    // runs a full command and records the start-strobe pattern over the 3 cycles after the opcode
    task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input int gap,
                          output logic [2:0] st, output logic [7:0] d, output logic busy_after);
        send_byte(a, 1'b1);
        repeat (gap) tick();
        send_byte(b, 1'b1);
        repeat (gap) tick();
        send_byte(op, 1'b1);
        st[0] = tx_start;
        tick();
        st[1] = tx_start;
        d = tx_data;
        tick();
        st[2] = tx_start;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        busy_after = busy;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        total++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, error, overrun} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got a=%h b=%h op=%h tx=%h st=%b busy=%b err=%b ovr=%b want all 0",
                     alu_a, alu_b, alu_op, tx_data, tx_start, busy, error, overrun);
        end
    endtask

    task automatic test_nominal();
        logic [2:0] st;
        logic [7:0] d;
        logic ba;
        do_cmd(8'h05, 8'h03, 8'h20, 0, st, d, ba);
        total++;
        if ({alu_a, alu_b, alu_op} !== {8'h05, 8'h03, 6'h20}) begin
            bad++;
            $display("FAIL nominal_operands got %h %h %h want 05 03 20", alu_a, alu_b, alu_op);
        end
        total++;
        if (d !== 8'h08) begin bad++; $display("FAIL nominal_result got %h want 08", d); end
        total++;
        if (st !== 3'b010) begin bad++; $display("FAIL nominal_start_timing got %b want 010", st); end
        total++;
        if (ba !== 1'b0) begin bad++; $display("FAIL nominal_idle_busy got %b want 0", ba); end
    endtask

    task automatic test_parity();
        logic [2:0] st;
        logic [7:0] d;
        logic ba;
        int e0;
        e0 = err_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h5A, 1'b0);
        total++;
        if (error !== 1'b1) begin bad++; $display("FAIL parity_error_pulse got %b want 1", error); end
        tick();
        total++;
        if (error !== 1'b0 || err_cnt - e0 != 1) begin
            bad++;
            $display("FAIL parity_error_width got err=%b pulses=%0d want 0 and 1", error, err_cnt - e0);
        end
        total++;
        if (alu_a !== 8'h11) begin bad++; $display("FAIL parity_keeps_a got %h want 11", alu_a); end
        do_cmd(8'h22, 8'h01, 8'h20, 0, st, d, ba);
        total++;
        if (d !== 8'h23 || st !== 3'b010) begin
            bad++;
            $display("FAIL parity_resync got data=%h st=%b want 23 010", d, st);
        end
        send_byte(8'h33, 1'b0);
        total++;
        if (error !== 1'b1 || alu_a !== 8'h22) begin
            bad++;
            $display("FAIL parity_wait_a got err=%b a=%h want 1 22", error, alu_a);
        end
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b0);
        total++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL parity_wait_op got err=%b busy=%b want 1 0", error, busy);
        end
        do_cmd(8'hF0, 8'h3C, 8'h24, 1, st, d, ba);
        total++;
        if (d !== 8'h30 || alu_a !== 8'hF0) begin
            bad++;
            $display("FAIL parity_wait_op_resync got data=%h a=%h want 30 f0", d, alu_a);
        end
    endtask

    task automatic test_timeout();
        logic [2:0] st;
        logic [7:0] d;
        logic ba;
        int e0, first;
        e0 = err_cnt;
        first = -1;
        send_byte(8'h7F, 1'b1);
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (error && first < 0) first = k;
        end
        total++;
        if (first != TMO) begin bad++; $display("FAIL timeout_cycle got %0d want %0d", first, TMO); end
        total++;
        if (err_cnt - e0 != 1) begin bad++; $display("FAIL timeout_pulses got %0d want 1", err_cnt - e0); end
        do_cmd(8'h42, 8'h10, 8'h22, 0, st, d, ba);
        total++;
        if (alu_a !== 8'h42 || d !== 8'h32) begin
            bad++;
            $display("FAIL timeout_resync got a=%h data=%h want 42 32", alu_a, d);
        end
        // a byte on the very edge the timeout would fire is still taken
        e0 = err_cnt;
        send_byte(8'h01, 1'b1);
        repeat (TMO - 1) tick();
        send_byte(8'h02, 1'b1);
        total++;
        if (err_cnt - e0 != 0 || error !== 1'b0 || alu_b !== 8'h02) begin
            bad++;
            $display("FAIL timeout_byte_wins got pulses=%0d b=%h want 0 02", err_cnt - e0, alu_b);
        end
        repeat (TMO + 10) tick();
        total++;
        if (err_cnt - e0 != 1 || alu_b !== 8'h02) begin
            bad++;
            $display("FAIL timeout_wait_op got pulses=%0d b=%h want 1 02", err_cnt - e0, alu_b);
        end
    endtask

    task automatic test_overrun();
        int o0, e0;
        o0 = ovr_cnt;
        e0 = err_cnt;
        send_byte(8'h3C, 1'b1);
        send_byte(8'h0F, 1'b1);
        send_byte(8'h25, 1'b1);
        tick();
        tick();
        send_byte(8'hAA, 1'b1);
        total++;
        if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_pulse got %b want 1", overrun); end
        total++;
        if (alu_a !== 8'h3C || tx_data !== 8'h3F || busy !== 1'b1) begin
            bad++;
            $display("FAIL overrun_hold got a=%h tx=%h busy=%b want 3c 3f 1", alu_a, tx_data, busy);
        end
        tick();
        total++;
        if (overrun !== 1'b0 || ovr_cnt - o0 != 1 || err_cnt - e0 != 0) begin
            bad++;
            $display("FAIL overrun_width got ovr=%b pulses=%0d errs=%0d want 0 1 0", overrun, ovr_cnt - o0, err_cnt - e0);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL overrun_release got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] st;
        logic [7:0] d, a, b, op;
        logic ba;
        int s0;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        total++;
        if ({alu_a, alu_b, alu_op, tx_data, tx_start, busy, error, overrun} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs got a=%h b=%h op=%h tx=%h busy=%b want all 0", alu_a, alu_b, alu_op, tx_data, busy);
        end
        a = 8'($urandom);
        b = 8'($urandom);
        op = 8'h22;
        do_cmd(a, b, op, 0, st, d, ba);
        total++;
        if (d !== ref_alu(a, b, op[5:0]) || st !== 3'b010) begin
            bad++;
            $display("FAIL reset_mid_fresh got data=%h st=%b want %h 010", d, st, ref_alu(a, b, op[5:0]));
        end
        s0 = start_cnt;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h20, 1'b1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        total++;
        if (start_cnt - s0 != 0 || busy !== 1'b0 || tx_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_mid_exec got starts=%0d busy=%b tx=%h want 0 0 00", start_cnt - s0, busy, tx_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] st;
        logic [7:0] d, a, b, op;
        logic ba;
        int s0, e0, o0;
        s0 = start_cnt;
        e0 = err_cnt;
        o0 = ovr_cnt;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            op = 8'($urandom_range(32, 39)) | (8'($urandom_range(0, 3)) << 6);
            do_cmd(a, b, op, 0, st, d, ba);
            total++;
            if (d !== ref_alu(a, b, op[5:0]) || st !== 3'b010 || alu_op !== op[5:0]) begin
                bad++;
                $display("FAIL b2b_cmd%0d got data=%h st=%b op=%h want %h 010 %h", i, d, st, alu_op, ref_alu(a, b, op[5:0]), op[5:0]);
            end
        end
        tick();
        total++;
        if (start_cnt - s0 != 4 || err_cnt - e0 != 0 || ovr_cnt - o0 != 0) begin
            bad++;
            $display("FAIL b2b_counts got starts=%0d errs=%0d ovrs=%0d want 4 0 0", start_cnt - s0, err_cnt - e0, ovr_cnt - o0);
        end
    endtask

    task automatic test_random();
        logic [2:0] st;
        logic [7:0] d, a, b, op;
        logic ba;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            op = 8'($urandom);
            do_cmd(a, b, op, int'($urandom_range(0, 8)), st, d, ba);
            total++;
            if (d !== ref_alu(a, b, op[5:0]) || {alu_a, alu_b, alu_op} !== {a, b, op[5:0]} || ba !== 1'b0) begin
                bad++;
                $display("FAIL random_cmd%0d got a=%h b=%h op=%h data=%h want %h %h %h %h", i, alu_a, alu_b, alu_op, d, a, b, op[5:0], ref_alu(a, b, op[5:0]));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got no finish want finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        rx_data = '0;
        rx_done = 1'b0;
        rx_frame_valid = 1'b1;
        tx_done = 1'b0;
        test_reset();
        test_nominal();
        test_parity();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
